// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus hard-decision Viterbi decoder, one symbol per clock, no backpressure.
// Encoder latency 1 clk; decoder lags TB_LEN-1 symbols +1 clk. Define VITERBI_BM_ACC_EN for the dec_bm_acc error estimate.
module viterbi_codec #(
  parameter int TB_LEN = 16,
  parameter int PM_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_enable_i,
  input  logic        enc_d_in,
  output logic        enc_valid_o,
  output logic [1:0]  enc_d_out,
  input  logic        dec_enable,
  input  logic [1:0]  dec_d_in,
  output logic        dec_valid_o,
  output logic        dec_d_out
`ifdef VITERBI_BM_ACC_EN
  ,
  output logic [15:0] dec_bm_acc
`endif
);

  localparam int CW = PM_W + 1;
  localparam int FW = $clog2(TB_LEN + 1);
  localparam logic [PM_W-1:0] PM_INIT   = PM_W'(1) << (PM_W - 1);
  localparam logic [FW-1:0]   FILL_MAX  = FW'(TB_LEN);
  localparam logic [FW-1:0]   FILL_LAST = FW'(TB_LEN - 1);

  function automatic logic [1:0] f_exp(input logic b, input logic s1, input logic s0);
    return {b ^ s1 ^ s0, b ^ s0};
  endfunction

  function automatic logic [1:0] f_bm(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  logic [1:0] r_enc_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_st    <= 2'b00;
      enc_valid_o <= 1'b0;
      enc_d_out   <= 2'b00;
    end else if (enc_enable_i) begin
      enc_d_out   <= f_exp(enc_d_in, r_enc_st[1], r_enc_st[0]);
      r_enc_st    <= {enc_d_in, r_enc_st[1]};
      enc_valid_o <= 1'b1;
    end else begin
      enc_valid_o <= 1'b0;
      enc_d_out   <= 2'b00;
    end
  end

  logic [PM_W-1:0] r_pm   [4];
  logic [3:0]      r_surv [TB_LEN];
  logic [FW-1:0]   r_fill;

  logic [1:0]      w_bm0  [4];
  logic [1:0]      w_bm1  [4];
  logic [CW-1:0]   w_c0   [4];
  logic [CW-1:0]   w_c1   [4];
  logic [CW-1:0]   w_new  [4];
  logic [PM_W-1:0] w_norm [4];
  logic [3:0]      w_dec;
  logic [CW-1:0]   w_min;
  logic [1:0]      w_best;
  logic [1:0]      w_tb_st;
  logic            w_full;

  // Next state n={b,s1}; its predecessors are {n0,0} and {n0,1}, entered with b=n1.
  always_comb begin
    w_dec = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      w_bm0[n]  = f_bm(dec_d_in, f_exp(n[1], n[0], 1'b0));
      w_bm1[n]  = f_bm(dec_d_in, f_exp(n[1], n[0], 1'b1));
      w_c0[n]   = {1'b0, r_pm[{n[0], 1'b0}]} + CW'(w_bm0[n]);
      w_c1[n]   = {1'b0, r_pm[{n[0], 1'b1}]} + CW'(w_bm1[n]);
      w_dec[n]  = (w_c1[n] < w_c0[n]);
      w_new[n]  = w_dec[n] ? w_c1[n] : w_c0[n];
    end
  end

  always_comb begin
    w_min  = w_new[0];
    w_best = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (w_new[n] < w_min) begin
        w_min  = w_new[n];
        w_best = 2'(n);
      end
    end
    for (int n = 0; n < 4; n++) begin
      w_norm[n] = PM_W'(w_new[n] - w_min);
    end
  end

  // First step uses this symbol's decisions, the rest walk the stored survivors.
  always_comb begin
    w_tb_st = {w_best[0], w_dec[w_best]};
    for (int i = 0; i < TB_LEN - 2; i++) begin
      w_tb_st = {w_tb_st[0], r_surv[i][w_tb_st]};
    end
  end

  assign w_full = (r_fill >= FILL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i] <= (i == 0) ? '0 : PM_INIT;
      end
      for (int i = 0; i < TB_LEN; i++) begin
        r_surv[i] <= 4'b0000;
      end
      r_fill      <= '0;
      dec_valid_o <= 1'b0;
      dec_d_out   <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i] <= w_norm[i];
      end
      r_surv[0] <= w_dec;
      for (int i = 1; i < TB_LEN; i++) begin
        r_surv[i] <= r_surv[i-1];
      end
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + FW'(1);
      end
      dec_valid_o <= w_full;
      if (w_full) begin
        dec_d_out <= w_tb_st[1];
      end
    end else begin
      dec_valid_o <= 1'b0;
    end
  end

`ifdef VITERBI_BM_ACC_EN
  logic [15:0] r_bm_acc;
  logic [1:0]  w_best_bm;
  logic [16:0] w_acc_sum;

  assign w_best_bm = w_dec[w_best] ? w_bm1[w_best] : w_bm0[w_best];
  assign w_acc_sum = {1'b0, r_bm_acc} + 17'(w_best_bm);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bm_acc <= 16'h0000;
    end else if (dec_enable) begin
      r_bm_acc <= w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
    end
  end

  assign dec_bm_acc = r_bm_acc;
`endif

endmodule

// File: tb/tb_viterbi_codec.sv
// Randomised bench for viterbi_codec against a full-path-history Viterbi reference model.
module tb_viterbi_codec;
  localparam int TB_LEN = 16;
  localparam int PM_W   = 5;
  localparam int MAXN   = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       dec_valid_o;
  logic       dec_d_out;
`ifdef VITERBI_BM_ACC_EN
  logic [15:0] dec_bm_acc;
`endif

  always #5 clk = ~clk;

  viterbi_codec #(.TB_LEN(TB_LEN), .PM_W(PM_W)) dut (
`ifdef VITERBI_BM_ACC_EN
    .dec_bm_acc   (dec_bm_acc),
`endif
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_valid_o  (dec_valid_o),
    .dec_d_out    (dec_d_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: unnormalised metrics and full per-state path histories.
  int               m_pm [4];
  logic [MAXN-1:0]  m_hist [4];
  int               m_t;
  int               m_acc;
  logic [1:0]       m_enc_s;

  logic bits    [MAXN];
  logic got     [MAXN];
  logic ref_got [MAXN];
  int   got_n;
  int   first_vld;

  function automatic logic [1:0] enc_sym(input logic b, input logic [1:0] s);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  task automatic m_reset();
    m_pm[0] = 0;
    for (int s = 1; s < 4; s++) m_pm[s] = 1 << (PM_W - 1);
    for (int s = 0; s < 4; s++) m_hist[s] = '0;
    m_t = 0;
    m_acc = 0;
    m_enc_s = 2'b00;
  endtask

  task automatic m_dec_step(input logic [1:0] rx, output logic vld, output logic bit_o);
    int npm [4];
    int nbm [4];
    logic [MAXN-1:0] nh [4];
    int nxt, bm, cost, best;
    for (int n = 0; n < 4; n++) begin
      npm[n] = 1 << 30;
      nbm[n] = 0;
      nh[n]  = '0;
    end
    // Visiting predecessors in ascending order with strict '<' keeps the s0=0 one on ties.
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 2; b++) begin
        nxt  = b * 2 + s / 2;
        bm   = $countones(rx ^ enc_sym(b[0], s[1:0]));
        cost = m_pm[s] + bm;
        if (cost < npm[nxt]) begin
          npm[nxt] = cost;
          nbm[nxt] = bm;
          nh[nxt]  = m_hist[s];
          nh[nxt][m_t] = b[0];
        end
      end
    end
    best = 0;
    for (int n = 1; n < 4; n++) if (npm[n] < npm[best]) best = n;
    m_acc = m_acc + nbm[best];
    if (m_acc > 65535) m_acc = 65535;
    vld   = (m_t >= TB_LEN - 1);
    bit_o = vld ? nh[best][m_t - (TB_LEN - 1)] : 1'b0;
    m_pm   = npm;
    m_hist = nh;
    m_t++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enc_enable_i = 1'b0;
    dec_enable = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_enc_vld", 32'(enc_valid_o), 32'd0);
    check_eq("reset_enc_sym", 32'(enc_d_out), 32'd0);
    check_eq("reset_dec_vld", 32'(dec_valid_o), 32'd0);
    check_eq("reset_dec_bit", 32'(dec_d_out), 32'd0);
`ifdef VITERBI_BM_ACC_EN
    check_eq("reset_bm_acc", 32'(dec_bm_acc), 32'd0);
`endif
    rst = 1'b0;
    m_reset();
  endtask

  task automatic prep(input int n);
    for (int t = 0; t < n; t++) bits[t] = 1'($urandom);
    for (int t = n; t < n + TB_LEN; t++) bits[t] = 1'b0;
  endtask

  // mode 0 clean, 1 one flip per 16, 2 burst at 27..30 of each 32, 3 one burst at 27..30
  task automatic run(input int n_sym, input int mode, input bit gaps, input int rst_at);
    logic [1:0] sym, rx;
    logic ev, eb, exp_last;
    bit have_last;
    got_n = 0;
    first_vld = -1;
    have_last = 0;
    exp_last = 1'b0;
    for (int t = 0; t < n_sym; t++) begin
      if (t == rst_at) begin
        rst = 1'b1;
        enc_enable_i = 1'b1;
        enc_d_in = 1'b1;
        dec_enable = 1'b1;
        dec_d_in = 2'b11;
        @(posedge clk); #1;
        check_eq("midrst_enc_vld", 32'(enc_valid_o), 32'd0);
        check_eq("midrst_enc_sym", 32'(enc_d_out), 32'd0);
        check_eq("midrst_dec_vld", 32'(dec_valid_o), 32'd0);
        check_eq("midrst_dec_bit", 32'(dec_d_out), 32'd0);
        rst = 1'b0;
        enc_enable_i = 1'b0;
        dec_enable = 1'b0;
        m_reset();
        return;
      end
      sym = enc_sym(bits[t], m_enc_s);
      m_enc_s = {bits[t], m_enc_s[1]};
      rx = sym;
      case (mode)
        1: if (t % 16 == 8) rx[0] = ~rx[0];
        2: if (t % 32 >= 27 && t % 32 <= 30) rx[0] = ~rx[0];
        3: if (t >= 27 && t <= 30) rx[0] = ~rx[0];
        default: ;
      endcase
      m_dec_step(rx, ev, eb);
      enc_enable_i = 1'b1;
      enc_d_in = bits[t];
      dec_enable = 1'b1;
      dec_d_in = rx;
      @(posedge clk); #1;
      check_eq("enc_vld", 32'(enc_valid_o), 32'd1);
      check_eq("enc_sym", 32'(enc_d_out), 32'(sym));
      check_eq("dec_vld", 32'(dec_valid_o), 32'(ev));
      if (ev) begin
        check_eq("dec_bit", 32'(dec_d_out), 32'(eb));
        got[got_n] = dec_d_out;
        got_n++;
        exp_last = eb;
        have_last = 1;
        if (first_vld < 0) first_vld = t + 1;
      end
`ifdef VITERBI_BM_ACC_EN
      check_eq("bm_acc", 32'(dec_bm_acc), 32'(m_acc));
`endif
      if (gaps) begin
        enc_enable_i = 1'b0;
        dec_enable = 1'b0;
        enc_d_in = 1'($urandom);
        dec_d_in = 2'($urandom);
        @(posedge clk); #1;
        check_eq("gap_enc_vld", 32'(enc_valid_o), 32'd0);
        check_eq("gap_enc_sym", 32'(enc_d_out), 32'd0);
        check_eq("gap_dec_vld", 32'(dec_valid_o), 32'd0);
        if (have_last) check_eq("gap_hold", 32'(dec_d_out), 32'(exp_last));
      end
    end
    enc_enable_i = 1'b0;
    dec_enable = 1'b0;
  endtask

  function automatic int count_errs(input int n, input int lo);
    int e;
    e = 0;
    for (int k = lo; k < n; k++) begin
      if (k >= got_n || got[k] !== bits[k]) e++;
    end
    return e;
  endfunction

  logic [1:0] imp_exp [4];
  int mism;

  initial begin
    imp_exp[0] = 2'b11;
    imp_exp[1] = 2'b10;
    imp_exp[2] = 2'b11;
    imp_exp[3] = 2'b00;

    do_reset();

    for (int i = 0; i < 4; i++) begin
      enc_enable_i = 1'b1;
      enc_d_in = (i == 0);
      @(posedge clk); #1;
      check_eq("impulse_vld", 32'(enc_valid_o), 32'd1);
      check_eq("impulse_sym", 32'(enc_d_out), 32'(imp_exp[i]));
    end
    enc_enable_i = 1'b0;

    do_reset();
    prep(256);
    run(256 + TB_LEN, 0, 0, -1);
    check_eq("clean_count", 32'(got_n), 32'd257);
    check_eq("clean_errs", 32'(count_errs(256, 0)), 32'd0);
    check_eq("clean_first_vld", 32'(first_vld), 32'(TB_LEN));
    for (int k = 0; k < got_n; k++) ref_got[k] = got[k];

    do_reset();
    run(256 + TB_LEN, 0, 1, -1);
    check_eq("gaps_count", 32'(got_n), 32'd257);
    mism = 0;
    for (int k = 0; k < 257; k++) if (got[k] !== ref_got[k]) mism++;
    check_eq("gaps_vs_gapfree", 32'(mism), 32'd0);

    do_reset();
    prep(256);
    run(256 + TB_LEN, 1, 0, -1);
    check_eq("single_err_errs", 32'(count_errs(256, 0)), 32'd0);

    do_reset();
    prep(256);
    run(256 + TB_LEN, 2, 0, -1);
    $display("burst pattern: %0d decoded bit errors out of 256", count_errs(256, 0));

    do_reset();
    prep(200);
    run(200 + TB_LEN, 3, 0, -1);
    check_eq("burst_resync", 32'(count_errs(200, 31 + 2 * TB_LEN)), 32'd0);

    do_reset();
    prep(150);
    run(150 + TB_LEN, 0, 0, 100);
    prep(60);
    run(60 + TB_LEN, 0, 0, -1);
    check_eq("restart_first_vld", 32'(first_vld), 32'(TB_LEN));
    check_eq("restart_errs", 32'(count_errs(60, 0)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
